// File: rtl/prism_sp_puzzle_pkg.sv
// Slice-layout helpers shared by the puzzle FIFO push and pop units so both
// ends agree on how a full-width word is cut into OUT_WIDTH slices.
package prism_sp_puzzle_pkg;

  function automatic int puzzle_nwords(input int data_w, input int slice_w);
    return data_w / slice_w;
  endfunction

  function automatic int puzzle_lastidx(input int data_w, input int slice_w);
    return ((data_w % slice_w) != 0) ? (data_w / slice_w) : (data_w / slice_w) - 1;
  endfunction

  function automatic int puzzle_lastnbits(input int data_w, input int slice_w);
    return ((data_w % slice_w) != 0) ? (data_w % slice_w) : slice_w;
  endfunction

endpackage

// File: rtl/prism_sp_unit_puzzle_fifo_r_pop_if.sv
// Read port of a FIFO whose data is valid the cycle after rd_en.
interface fifo_read_interface #(
  parameter int DATA_WIDTH = 72
) ();
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  empty;

  modport master (output rd_en, input rd_data, input empty);
  modport slave  (input rd_en, output rd_data, output empty);
endinterface

// File: rtl/prism_sp_unit_puzzle_fifo_r_pop_slice_mux.sv
// Selects one OUT_WIDTH slice of a word, lowest slice at sel=0; the final
// partial slice comes out zero-extended.
module prism_sp_puzzle_slice_mux
  import prism_sp_puzzle_pkg::*;
#(
  parameter int DATA_WIDTH = 72,
  parameter int OUT_WIDTH  = 32,
  parameter int SEL_W      = 2
) (
  input  logic [DATA_WIDTH-1:0] word,
  input  logic [SEL_W-1:0]      sel,
  output logic [OUT_WIDTH-1:0]  slice
);

  localparam int NSLICES = puzzle_lastidx(DATA_WIDTH, OUT_WIDTH) + 1;
  localparam int PAD_W   = NSLICES * OUT_WIDTH;

  logic [PAD_W-1:0]                  flat;
  logic [NSLICES-1:0][OUT_WIDTH-1:0] slices;

  // Padding the word to a whole number of slices yields the zero extension.
  always_comb begin
    flat                   = '0;
    flat[DATA_WIDTH-1:0]   = word;
  end

  assign slices = flat;
  assign slice  = slices[sel];

endmodule

// File: rtl/prism_sp_unit_puzzle_fifo_r_pop.sv
// Pops full-width FIFO words and presents them as OUT_WIDTH slices, lowest
// first; a current+next holding stage hides refill latency.
module prism_sp_unit_puzzle_fifo_r_pop
  import prism_sp_puzzle_pkg::*;
#(
  parameter int OUT_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pulse,
  fifo_read_interface.master       fifo_r,
  output logic [OUT_WIDTH-1:0]     out,
  output logic                     valid,
  output logic                     underrun
);

  localparam int DATA_WIDTH = fifo_r.DATA_WIDTH;
  localparam int LASTIDX    = puzzle_lastidx(DATA_WIDTH, OUT_WIDTH);
  localparam int SEL_W      = (LASTIDX > 0) ? $clog2(LASTIDX + 1) : 1;
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(LASTIDX);

  logic [DATA_WIDTH-1:0] cur_word;
  logic [DATA_WIDTH-1:0] nxt_word;
  logic                  cur_v;
  logic                  nxt_v;
  logic [SEL_W-1:0]      sel;
  logic                  pending;
  logic                  rd_en;

  logic                  consume;
  logic                  at_last;
  logic                  land_cur;
  logic                  land_nxt;
  logic                  promote;
  logic [OUT_WIDTH-1:0]  slice;

  assign consume  = pulse && cur_v;
  assign at_last  = (sel == LAST_SEL);
  // A returning word goes straight to cur when cur is empty or being vacated.
  assign land_cur = pending && (!cur_v || (consume && at_last && !nxt_v));
  assign land_nxt = pending && !land_cur;
  assign promote  = consume && at_last && nxt_v;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; later assignments in a block win.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_en    <= 1'b0;
      pending  <= 1'b0;
      cur_v    <= 1'b0;
      nxt_v    <= 1'b0;
      sel      <= '0;
      underrun <= 1'b0;
    end else begin
      rd_en   <= !fifo_r.empty && !rd_en && !pending && !nxt_v;
      pending <= rd_en;
      if (pulse && !cur_v) underrun <= 1'b1;

      if (consume) begin
        if (!at_last) begin
          sel <= sel + SEL_W'(1);
        end else begin
          sel <= '0;
          if (nxt_v) nxt_v <= 1'b0;
          else       cur_v <= 1'b0;
        end
      end

      if (land_cur) begin
        cur_v <= 1'b1;
        sel   <= '0;
      end
      if (land_nxt) nxt_v <= 1'b1;
    end
  end

  // NOTE: the word registers carry no reset; the valid flags qualify them.
  always_ff @(posedge clk) begin
    if (land_cur)     cur_word <= fifo_r.rd_data;
    else if (promote) cur_word <= nxt_word;
    if (land_nxt)     nxt_word <= fifo_r.rd_data;
  end

  prism_sp_puzzle_slice_mux #(
    .DATA_WIDTH (DATA_WIDTH),
    .OUT_WIDTH  (OUT_WIDTH),
    .SEL_W      (SEL_W)
  ) u_slice_mux (
    .word  (cur_word),
    .sel   (sel),
    .slice (slice)
  );

  assign fifo_r.rd_en = rd_en;
  assign valid        = cur_v;
  assign out          = cur_v ? slice : '0;

endmodule

// File: tb/tb_prism_sp_unit_puzzle_fifo_r_pop.sv
// Bench for the puzzle FIFO pop unit: a 72/32 instance and a 32/32 instance,
// each fed by a queue-based FIFO and checked against an expected-slice queue.
module tb_prism_sp_unit_puzzle_fifo_r_pop;

  logic        clk;
  logic        rst;
  logic        pulse_a, pulse_b;
  logic [31:0] out_a, out_b;
  logic        valid_a, valid_b;
  logic        underrun_a, underrun_b;

  fifo_read_interface #(.DATA_WIDTH(72)) bus_a ();
  fifo_read_interface #(.DATA_WIDTH(32)) bus_b ();

  prism_sp_unit_puzzle_fifo_r_pop #(.OUT_WIDTH(32)) dut_a (
    .clk      (clk),
    .rst      (rst),
    .pulse    (pulse_a),
    .fifo_r   (bus_a),
    .out      (out_a),
    .valid    (valid_a),
    .underrun (underrun_a)
  );

  prism_sp_unit_puzzle_fifo_r_pop #(.OUT_WIDTH(32)) dut_b (
    .clk      (clk),
    .rst      (rst),
    .pulse    (pulse_b),
    .fifo_r   (bus_b),
    .out      (out_b),
    .valid    (valid_b),
    .underrun (underrun_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  logic [71:0] fq_a[$];
  logic [31:0] fq_b[$];
  logic [31:0] eq_a[$], eq_b[$];
  logic [31:0] obs_a[$], obs_b[$];
  logic        exp_ur_a = 1'b0, exp_ur_b = 1'b0;
  logic        prev_rd_a = 1'b0, prev_rd_b = 1'b0;
  int          rd_cnt_a = 0;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] slice_of(input logic [71:0] w, input int i);
    return 32'(w >> (32 * i));
  endfunction

  function automatic logic [71:0] rand72();
    return {8'($urandom()), $urandom(), $urandom()};
  endfunction

  // One clock: check outputs at the falling edge, serve the FIFO, then drive
  // pulse (mode 0 off, 1 on, 2 only when valid) and reset for the next edge.
  task automatic step(input int ma, input int mb, input bit r);
    logic [71:0] wa;
    logic [31:0] wb;
    @(negedge clk);
    check("underrun_a", underrun_a, exp_ur_a);
    check("underrun_b", underrun_b, exp_ur_b);
    if (valid_a) begin
      if (eq_a.size() == 0) check("a_spurious_valid", valid_a, 0);
      else                  check("out_a", out_a, eq_a[0]);
    end
    if (valid_b) begin
      if (eq_b.size() == 0) check("b_spurious_valid", valid_b, 0);
      else                  check("out_b", out_b, eq_b[0]);
    end
    check("a_rd_back_to_back", prev_rd_a & bus_a.rd_en, 0);
    check("b_rd_back_to_back", prev_rd_b & bus_b.rd_en, 0);
    check("a_pending_and_nxt", dut_a.pending & dut_a.nxt_v, 0);
    check("b_pending_and_nxt", dut_b.pending & dut_b.nxt_v, 0);

    if (bus_a.rd_en) begin
      rd_cnt_a++;
      if (fq_a.size() == 0) check("a_rd_when_empty", bus_a.rd_en, 0);
      else begin
        wa = fq_a.pop_front();
        bus_a.rd_data = wa;
        for (int i = 0; i < (72 + 31) / 32; i++) eq_a.push_back(slice_of(wa, i));
      end
    end
    if (bus_b.rd_en) begin
      if (fq_b.size() == 0) check("b_rd_when_empty", bus_b.rd_en, 0);
      else begin
        wb = fq_b.pop_front();
        bus_b.rd_data = wb;
        eq_b.push_back(wb);
      end
    end
    prev_rd_a   = bus_a.rd_en;
    prev_rd_b   = bus_b.rd_en;
    bus_a.empty = (fq_a.size() == 0);
    bus_b.empty = (fq_b.size() == 0);

    rst = r;
    if (r) begin
      pulse_a = 1'b0;
      pulse_b = 1'b0;
      eq_a.delete();
      eq_b.delete();
      exp_ur_a = 1'b0;
      exp_ur_b = 1'b0;
    end else begin
      pulse_a = (ma == 1) || (ma == 2 && valid_a);
      pulse_b = (mb == 1) || (mb == 2 && valid_b);
      if (pulse_a) begin
        if (valid_a) begin
          obs_a.push_back(out_a);
          if (eq_a.size() != 0) void'(eq_a.pop_front());
        end else exp_ur_a = 1'b1;
      end
      if (pulse_b) begin
        if (valid_b) begin
          obs_b.push_back(out_b);
          if (eq_b.size() != 0) void'(eq_b.pop_front());
        end else exp_ur_b = 1'b1;
      end
    end
    @(posedge clk);
  endtask

  task automatic wait_valid_a(input string tag);
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 0);
      #1;
      if (valid_a) break;
    end
    check(tag, valid_a, 1);
  endtask

  logic [71:0] words[4];
  logic [71:0] w3, w4a, w4b, w5a, w5b;
  logic [31:0] wb5[5];
  int          gaps;
  bit          seen;

  initial begin
    rst = 1'b1;
    pulse_a = 1'b0;
    pulse_b = 1'b0;
    bus_a.empty = 1'b1;
    bus_b.empty = 1'b1;
    bus_a.rd_data = '0;
    bus_b.rd_data = '0;

    // Reset state
    step(0, 0, 1);
    step(0, 0, 1);
    #1;
    check("rst_valid_a", valid_a, 0);
    check("rst_rd_en_a", bus_a.rd_en, 0);
    check("rst_underrun_a", underrun_a, 0);
    check("rst_valid_b", valid_b, 0);
    check("rst_rd_en_b", bus_b.rd_en, 0);

    // 1: single 72-bit word drained one slice per cycle
    fq_a.push_back(72'hAB_11223344_55667788);
    obs_a.delete();
    rd_cnt_a = 0;
    for (int i = 0; i < 20 && obs_a.size() < 3; i++) step(2, 0, 0);
    for (int i = 0; i < 4; i++) step(2, 0, 0);
    #1;
    check("t1_count", obs_a.size(), 3);
    check("t1_slice0", obs_a[0], 32'h55667788);
    check("t1_slice1", obs_a[1], 32'h11223344);
    check("t1_slice2", obs_a[2], 32'h000000AB);
    check("t1_valid_after", valid_a, 0);
    check("t1_rd_once", rd_cnt_a, 1);
    check("t1_underrun", underrun_a, 0);

    // 2: four words, pulse held high, no bubble once data starts
    for (int k = 0; k < 4; k++) begin
      words[k] = rand72();
      fq_a.push_back(words[k]);
    end
    obs_a.delete();
    gaps = 0;
    seen = 0;
    for (int i = 0; i < 60 && obs_a.size() < 12; i++) begin
      step(1, 0, 0);
      #1;
      if (valid_a) seen = 1;
      else if (seen && obs_a.size() < 12) gaps++;
    end
    check("t2_count", obs_a.size(), 12);
    check("t2_gaps", gaps, 0);
    for (int k = 0; k < 12; k++) check("t2_slice", obs_a[k], slice_of(words[k / 3], k % 3));
    check("t2_underrun", underrun_a, 1);

    // 3: pulse with no data sets sticky underrun without consuming anything
    step(0, 0, 1);
    step(0, 0, 0);
    #1;
    check("t3_underrun_clear", underrun_a, 0);
    obs_a.delete();
    for (int i = 0; i < 4; i++) step(1, 0, 0);
    #1;
    check("t3_underrun_set", underrun_a, 1);
    check("t3_valid", valid_a, 0);
    check("t3_nothing_consumed", obs_a.size(), 0);
    w3 = rand72();
    fq_a.push_back(w3);
    wait_valid_a("t3_valid_timeout");
    check("t3_first_slice", out_a, slice_of(w3, 0));
    check("t3_underrun_hold", underrun_a, 1);
    for (int i = 0; i < 20 && obs_a.size() < 3; i++) step(2, 0, 0);
    check("t3_count", obs_a.size(), 3);

    // 4: second word lands on the cycle the last slice of the first is taken
    w4a = rand72();
    w4b = rand72();
    fq_a.push_back(w4a);
    fq_a.push_back(w4b);
    obs_a.delete();
    wait_valid_a("t4_valid_timeout");
    step(1, 0, 0);
    step(1, 0, 0);
    #1;
    check("t4_pending_at_last", dut_a.pending, 1);
    check("t4_last_slice", out_a, slice_of(w4a, 2));
    step(1, 0, 0);
    #1;
    check("t4_valid_held", valid_a, 1);
    check("t4_new_slice0", out_a, slice_of(w4b, 0));
    for (int i = 0; i < 20 && obs_a.size() < 6; i++) step(2, 0, 0);
    check("t4_count", obs_a.size(), 6);

    // 5: reset while a read is in flight drops the returning word
    w5a = rand72();
    w5b = rand72();
    fq_a.push_back(w5a);
    fq_a.push_back(w5b);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0);
      #1;
      if (bus_a.rd_en) break;
    end
    check("t5_rd_seen", bus_a.rd_en, 1);
    step(0, 0, 0);
    step(0, 0, 1);
    #1;
    check("t5_valid_in_reset", valid_a, 0);
    check("t5_pending_cleared", dut_a.pending, 0);
    obs_a.delete();
    wait_valid_a("t5_valid_timeout");
    check("t5_next_word", out_a, slice_of(w5b, 0));
    for (int i = 0; i < 20 && obs_a.size() < 3; i++) step(2, 0, 0);
    check("t5_count", obs_a.size(), 3);
    check("t5_last", obs_a[2], slice_of(w5b, 2));

    // 6: 32/32 instance, each pulse takes a whole word
    for (int k = 0; k < 5; k++) begin
      wb5[k] = $urandom();
      fq_b.push_back(wb5[k]);
    end
    obs_b.delete();
    for (int i = 0; i < 60 && obs_b.size() < 5; i++) step(0, 2, 0);
    check("t6_count", obs_b.size(), 5);
    for (int k = 0; k < 5; k++) check("t6_word", obs_b[k], wb5[k]);
    step(0, 0, 0);
    step(0, 0, 0);
    #1;
    check("t6_valid_after", valid_b, 0);
    check("t6_underrun", underrun_b, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
